// File: rtl/popcount_seq_if.sv
// Handshake/data bundle for popcount_seq: request side (valid, mode, data,
// abort) driven by the master, status/result side driven by the engine.
interface popcount_seq_if #(
  parameter int DATA_W = 16,
  parameter int SUM_W  = $clog2(DATA_W + 1)
);
  logic              i_valid;
  logic [1:0]        i_mode;
  logic [DATA_W-1:0] i_data;
  logic              i_abort;
  logic              o_ready;
  logic              o_busy;
  logic              o_done;
  logic [SUM_W-1:0]  o_sum;

  modport master (
    output i_valid, i_mode, i_data, i_abort,
    input  o_ready, o_busy, o_done, o_sum
  );

  modport slave (
    input  i_valid, i_mode, i_data, i_abort,
    output o_ready, o_busy, o_done, o_sum
  );
endinterface

// File: rtl/popcount_seq.sv
// Sequential bit-statistics engine: scans one bit per clock and returns the
// ones count, zeros count, leading-zero count or trailing-zero count of a
// captured DATA_W-bit word. Variable latency, minimal datapath.
module popcount_seq #(
  parameter int DATA_W = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  popcount_seq_if.slave  bus
);

  localparam int SUM_W = $clog2(DATA_W + 1);
  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [1:0]          mode_q,  mode_d;
  logic [SUM_W-1:0]    acc_q,   acc_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic [SUM_W-1:0]    sum_q,   sum_d;

  logic                bit_b;
  logic                inc;
  logic [DATA_W-1:0]   shreg_shift;
  logic [SUM_W-1:0]    acc_inc;
  logic                scan_end;

  // Per-cycle scan datapath: examined bit, increment, shifted word, end test.
  always_comb begin
    bit_b       = (mode_q == 2'd3) ? shreg_q[0] : shreg_q[DATA_W-1];
    inc         = (mode_q == 2'd0) ? bit_b : ~bit_b;
    shreg_shift = (mode_q == 2'd3) ? {1'b0, shreg_q[DATA_W-1:1]}
                                   : {shreg_q[DATA_W-2:0], 1'b0};
    acc_inc     = acc_q + SUM_W'(inc);
    scan_end    = (idx_q == IDX_W'(DATA_W - 1))
               || ((mode_q == 2'd0) && (shreg_shift == '0))
               || (mode_q[1] && bit_b);
  end

  // Next-state and datapath-load decisions; abort overrides scan completion.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_valid) begin
          state_d = S_RUN;
          shreg_d = bus.i_data;
          mode_d  = bus.i_mode;
          acc_d   = '0;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        if (bus.i_abort) begin
          state_d = S_IDLE;
        end else begin
          shreg_d = shreg_shift;
          acc_d   = acc_inc;
          idx_d   = idx_q + IDX_W'(1);
          if (scan_end) begin
            state_d = S_DONE;
            sum_d   = acc_inc;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      mode_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
    end
  end

  // Status outputs decode straight from the state register.
  assign bus.o_ready = (state_q == S_IDLE);
  assign bus.o_busy  = (state_q == S_RUN);
  assign bus.o_done  = (state_q == S_DONE);
  assign bus.o_sum   = sum_q;

endmodule

// File: tb/tb_popcount_seq.sv
// Bench for popcount_seq: directed DATA_W=8 vectors, abort/reset/hold
// sequences, and a DATA_W=13 random regression against a reference model.
module tb_popcount_seq;

  logic i_clk;
  logic i_rst_n;

  popcount_seq_if #(.DATA_W(8))  bus8 ();
  popcount_seq_if #(.DATA_W(13)) bus13 ();

  popcount_seq #(.DATA_W(8))  u_dut8  (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus8));
  popcount_seq #(.DATA_W(13)) u_dut13 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus13));

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [7:0] data;
    int         n;
    int         sum;
  } vec_t;

  vec_t vecs[14];

  // One transaction on the selected DUT; returns RUN length, result, the
  // number of o_done cycles seen and o_ready one cycle after o_done.
  task automatic xact(input bit w13, input logic [1:0] mode, input logic [63:0] data,
                      output int n, output int sum, output int dones,
                      output bit rdy_after, output bit tmo);
    @(negedge i_clk);
    if (w13) begin
      bus13.i_valid = 1'b1; bus13.i_mode = mode; bus13.i_data = data[12:0];
    end else begin
      bus8.i_valid = 1'b1; bus8.i_mode = mode; bus8.i_data = data[7:0];
    end
    @(negedge i_clk);
    bus8.i_valid  = 1'b0;
    bus13.i_valid = 1'b0;
    n = 0; sum = -1; dones = 0; tmo = 1'b1; rdy_after = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (w13 ? bus13.o_done : bus8.o_done) begin
        dones++;
        sum = w13 ? int'(bus13.o_sum) : int'(bus8.o_sum);
        tmo = 1'b0;
        break;
      end
      if (w13 ? bus13.o_busy : bus8.o_busy) n++;
      @(negedge i_clk);
    end
    @(negedge i_clk);
    rdy_after = w13 ? bus13.o_ready : bus8.o_ready;
    if (w13 ? bus13.o_done : bus8.o_done) dones++;
  endtask

  function automatic void model(input int w, input logic [1:0] mode, input logic [63:0] d,
                                output int n, output int sum);
    int ones = 0;
    int lo = -1;
    int hi = -1;
    int clz, ctz;
    for (int i = 0; i < w; i++) begin
      if (d[i]) begin
        ones++;
        if (lo < 0) lo = i;
        hi = i;
      end
    end
    ctz = (lo < 0) ? w : lo;
    clz = (hi < 0) ? w : (w - 1 - hi);
    case (mode)
      2'd0: begin sum = ones;     n = (lo < 0) ? 1 : (w - lo); end
      2'd1: begin sum = w - ones; n = w; end
      2'd2: begin sum = clz;      n = (clz + 1 > w) ? w : clz + 1; end
      default: begin sum = ctz;   n = (ctz + 1 > w) ? w : ctz + 1; end
    endcase
  endfunction

  initial begin
    int n, sum, dones, last, en, esum;
    bit rdy, tmo, spacing_ok;
    logic [1:0]  rmode;
    logic [63:0] rdata;

    vecs[0]  = '{2'd0, 8'hB4, 6, 4};
    vecs[1]  = '{2'd0, 8'h00, 1, 0};
    vecs[2]  = '{2'd0, 8'hFF, 8, 8};
    vecs[3]  = '{2'd0, 8'h01, 8, 1};
    vecs[4]  = '{2'd1, 8'hB4, 8, 4};
    vecs[5]  = '{2'd1, 8'h00, 8, 8};
    vecs[6]  = '{2'd1, 8'hFF, 8, 0};
    vecs[7]  = '{2'd2, 8'h1C, 4, 3};
    vecs[8]  = '{2'd2, 8'h00, 8, 8};
    vecs[9]  = '{2'd2, 8'h80, 1, 0};
    vecs[10] = '{2'd3, 8'h1C, 3, 2};
    vecs[11] = '{2'd3, 8'h01, 1, 0};
    vecs[12] = '{2'd3, 8'h80, 8, 7};
    vecs[13] = '{2'd3, 8'h00, 8, 8};

    i_rst_n = 1'b0;
    bus8.i_valid = 1'b0;  bus8.i_mode = '0;  bus8.i_data = '0;  bus8.i_abort = 1'b0;
    bus13.i_valid = 1'b0; bus13.i_mode = '0; bus13.i_data = '0; bus13.i_abort = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_ready", bus8.o_ready, 1);
    check("rst_busy",  bus8.o_busy,  0);
    check("rst_done",  bus8.o_done,  0);
    check("rst_sum",   bus8.o_sum,   0);
    check("rst_ready13", bus13.o_ready, 1);
    check("rst_sum13",   bus13.o_sum,   0);
    i_rst_n = 1'b1;

    // Directed DATA_W=8 table
    for (int i = 0; i < 14; i++) begin
      xact(1'b0, vecs[i].mode, 64'(vecs[i].data), n, sum, dones, rdy, tmo);
      check($sformatf("v%0d_timeout", i), tmo, 0);
      check($sformatf("v%0d_sum", i), sum, vecs[i].sum);
      check($sformatf("v%0d_n", i), n, vecs[i].n);
      check($sformatf("v%0d_done_pulses", i), dones, 1);
      check($sformatf("v%0d_ready_after", i), rdy, 1);
    end

    // Abort in the 3rd RUN cycle with o_sum previously 5
    xact(1'b0, 2'd0, 64'h1F, n, sum, dones, rdy, tmo);
    check("pre_abort_sum", sum, 5);
    @(negedge i_clk);
    bus8.i_valid = 1'b1; bus8.i_mode = 2'd1; bus8.i_data = 8'h0F;
    dones = 0;
    @(negedge i_clk);
    bus8.i_valid = 1'b0;
    if (bus8.o_done) dones++;
    @(negedge i_clk);
    if (bus8.o_done) dones++;
    @(negedge i_clk);
    if (bus8.o_done) dones++;
    bus8.i_abort = 1'b1;
    @(negedge i_clk);
    bus8.i_abort = 1'b0;
    check("abort_ready", bus8.o_ready, 1);
    check("abort_busy",  bus8.o_busy,  0);
    check("abort_sum",   bus8.o_sum,   5);
    for (int c = 0; c < 10; c++) begin
      if (bus8.o_done) dones++;
      @(negedge i_clk);
    end
    check("abort_no_done", dones, 0);
    xact(1'b0, 2'd3, 64'h1C, n, sum, dones, rdy, tmo);
    check("post_abort_sum", sum, 2);
    check("post_abort_n", n, 3);

    // Abort coinciding with the terminating cycle
    @(negedge i_clk);
    bus8.i_valid = 1'b1; bus8.i_mode = 2'd3; bus8.i_data = 8'h01;
    @(negedge i_clk);
    bus8.i_valid = 1'b0;
    bus8.i_abort = 1'b1;
    dones = 0;
    @(negedge i_clk);
    bus8.i_abort = 1'b0;
    check("abort_end_ready", bus8.o_ready, 1);
    for (int c = 0; c < 4; c++) begin
      if (bus8.o_done) dones++;
      @(negedge i_clk);
    end
    check("abort_end_no_done", dones, 0);
    check("abort_end_sum", bus8.o_sum, 2);

    // i_valid held high: accepts only in IDLE, period N+2 = 3
    bus8.i_valid = 1'b1; bus8.i_mode = 2'd0; bus8.i_data = 8'h00;
    dones = 0; last = -1; spacing_ok = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge i_clk);
      if (bus8.o_done) begin
        if (last >= 0 && (c - last) != 3) spacing_ok = 1'b0;
        last = c;
        dones++;
      end
    end
    bus8.i_valid = 1'b0;
    check("hold_done_count", dones, 4);
    check("hold_spacing", spacing_ok, 1);
    check("hold_sum", bus8.o_sum, 0);
    repeat (3) @(negedge i_clk);

    // Asynchronous reset during RUN (o_sum nonzero beforehand)
    xact(1'b0, 2'd1, 64'h00, n, sum, dones, rdy, tmo);
    check("pre_reset_sum", sum, 8);
    @(negedge i_clk);
    bus8.i_valid = 1'b1; bus8.i_mode = 2'd1; bus8.i_data = 8'hFF;
    @(negedge i_clk);
    bus8.i_valid = 1'b0;
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("midrst_sum",   bus8.o_sum,   0);
    check("midrst_ready", bus8.o_ready, 1);
    check("midrst_busy",  bus8.o_busy,  0);
    check("midrst_done",  bus8.o_done,  0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    xact(1'b0, 2'd2, 64'h1C, n, sum, dones, rdy, tmo);
    check("post_reset_sum", sum, 3);

    // DATA_W=13 random regression
    for (int t = 0; t < 1000; t++) begin
      rmode = 2'($urandom_range(0, 3));
      rdata = 64'($urandom) & 64'h1FFF;
      if ($urandom_range(0, 15) == 0) rdata = '0;
      model(13, rmode, rdata, en, esum);
      xact(1'b1, rmode, rdata, n, sum, dones, rdy, tmo);
      check($sformatf("r%0d_m%0d_d%0h_sum", t, rmode, rdata), sum, esum);
      check($sformatf("r%0d_m%0d_d%0h_n", t, rmode, rdata), n, en);
      check($sformatf("r%0d_done_pulses", t), dones, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
